// File: rtl/mux2_rr_arbiter.sv
// Purpose: round-robin select of two valid/ready sources into one registered output word plus source id.
// Latency: a word accepted on edge N is presented on y_data/sel/y_valid right after edge N.
// Backpressure: y_ready low with y_valid high stalls the register and holds a_ready/b_ready low.
module mux2_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             sel
);

    logic prio;
    logic load_en;
    logic gnt_vld;
    logic gnt_id;

    // Readies are masked while reset is held so no handshake is reported then.
    always_comb begin
        load_en = rst_n && (!y_valid || y_ready);
        gnt_vld = a_valid || b_valid;
        gnt_id  = (a_valid && b_valid) ? prio : b_valid;
        a_ready = load_en && gnt_vld && !gnt_id;
        b_ready = load_en && gnt_vld && gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            sel     <= 1'b0;
            prio    <= 1'b0;
        end else if (load_en) begin
            if (gnt_vld) begin
                y_valid <= 1'b1;
                y_data  <= gnt_id ? b_data : a_data;
                sel     <= gnt_id;
                prio    <= !gnt_id;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Upstream select-and-register stage for the 2:1 datapath mux.
- Accepts two independent valid/ready sources, A and B, and arbitrates between them round-robin.
- Registers the winning word into a single output stage, together with the `sel` bit identifying its source.
- Downstream logic consumes `y_data`/`sel` directly, or uses `sel` to steer a companion 2:1 MUX.

Parameters:
- WIDTH, 8, data word width of a_data, b_data and y_data.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  source A presents a word
- a_ready  output  1  source A word accepted this cycle (when a_valid=1)
- a_data  input  WIDTH  source A word
- b_valid  input  1  source B presents a word
- b_ready  output  1  source B word accepted this cycle (when b_valid=1)
- b_data  input  WIDTH  source B word
- y_valid  output  1  output register holds a word
- y_ready  input  1  consumer accepts y_data this cycle
- y_data  output  WIDTH  registered winning word
- sel  output  1  source of y_data: 0=A, 1=B (registered)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values (asserted immediately, independent of clk): y_valid=0, y_data=0, sel=0, internal priority pointer = A (A wins the first tie).
- Reset mid-transfer: the held word is discarded. No accept occurs while rst_n=0. The first accept is possible on the first rising edge after deassertion.
- Storage: one output register plus a 1-bit priority pointer (prio: 0=A preferred, 1=B preferred).
- load_en = !y_valid || y_ready. This is the output register's capacity to take a new word this cycle.
- Arbitration (combinational):
  - only a_valid -> grant A;
  - only b_valid -> grant B;
  - both -> grant the source indicated by prio;
  - neither -> no grant.
- Ready generation:
  - a_ready = load_en && grant==A; b_ready = load_en && grant==B.
  - Never both 1 in the same cycle.
  - Ready may depend combinationally on the valids and y_ready.
  - Sources must not make valid depend on ready.
- Transfer on rising edge, when a grant and load_en coincide:
  - y_data <= granted data; sel <= granted id; y_valid <= 1;
  - prio <= NOT granted id. The pointer flips after every accept, including uncontested accepts.
- Drain: y_valid && y_ready with no grant -> y_valid <= 0. y_data and sel hold their last values.
- Stall: y_valid && !y_ready -> y_data, sel and y_valid hold stable. a_ready=b_ready=0.
- Simultaneous pop and push: y_valid && y_ready with a grant -> new word loads in the same edge. y_valid stays 1. Full throughput, one word per cycle.
- Latency: an input accepted on edge N appears on y_data/sel/y_valid after edge N.
- Fairness: under continuous contention the grants strictly alternate A,B,A,B... No source waits more than one accept.
- Valid withdrawal: a source dropping valid without being granted is legal. The arbiter re-evaluates every cycle and keeps no latched grant.
- Width: data passes unmodified. No arithmetic.

Test Plan:
- Reset check: hold rst_n=0 with a_valid=1, a_data=8'h5A -> y_valid=0, y_data=8'h00, sel=0, and no accept. Assert rst_n=0 asynchronously mid-cycle while y_valid=1 -> y_valid drops to 0 before the next edge.
- Single source: b_valid=1, b_data=8'h3C, y_ready=1, a_valid=0 -> b_ready=1. After the edge: y_valid=1, y_data=8'h3C, sel=1.
- Contention fairness: a_valid=b_valid=1 continuously, with a_data=8'hAA, b_data=8'hBB, y_ready=1, starting from reset.
  - Output sequence is AA(sel0), BB(sel1), AA, BB over 4 cycles.
  - a_ready and b_ready are never high together.
- Backpressure: load 8'h11 from A, then hold y_ready=0 for 3 cycles with b_valid=1, b_data=8'h22.
  - y_data stays 8'h11 with sel=0, and b_ready=0 throughout.
  - On the cycle y_ready=1: b_ready=1, and after the edge y_data=8'h22, sel=1.
- Drain and hold: y_valid=1 with y_data=8'h77, y_ready=1, no input valid -> after the edge y_valid=0, and y_data stays 8'h77.
- Pointer after uncontested accept: A alone accepted (prio now B), then both valid -> B wins the next grant.
